// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared FSM state, zero-register index and port slice helper.
package reg_file_mp_pkg;
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  localparam int ZERO_REG = 0;
  function automatic int slice_off(input int port, input int w);
    return port * w;
  endfunction
endpackage

// File: rtl/reg_file_mp_bank.sv
// reg_file_mp_bank: 1W1R storage array, synchronous write, combinational range-checked read.
module reg_file_mp_bank #(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 32,
  parameter int LOG2NUMREGS = 5
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [LOG2NUMREGS-1:0] waddr_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic [LOG2NUMREGS-1:0] raddr_i,
  output logic [WIDTH-1:0]       rdata_o
);
  localparam logic [LOG2NUMREGS:0] DEPTH = (LOG2NUMREGS + 1)'(NUMREGS);
  logic [WIDTH-1:0] mem_q [NUMREGS];
  logic w_ok, r_ok;
  assign w_ok    = {1'b0, waddr_i} < DEPTH;
  assign r_ok    = {1'b0, raddr_i} < DEPTH;
  assign rdata_o = r_ok ? mem_q[raddr_i] : '0;
  always_ff @(posedge clk)
    if (we_i && w_ok) mem_q[waddr_i] <= wdata_i;
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: NUMRD-read/1-write register file with post-reset zeroing sweep.
// Define REG_FILE_MP_BYPASS_EN for write-first read/write collisions (read-first otherwise).
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 32,
  parameter int LOG2NUMREGS = 5,
  parameter int NUMRD       = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUMRD*LOG2NUMREGS-1:0] rd_reg,
  input  logic [NUMRD-1:0]             rd_en,
  output logic [NUMRD*WIDTH-1:0]       rd_data,
  input  logic [LOG2NUMREGS-1:0]       wr_reg,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         wr_we,
  output logic                         ready
);
  localparam logic [LOG2NUMREGS-1:0] LAST  = LOG2NUMREGS'(NUMREGS - 1);
  localparam logic [LOG2NUMREGS-1:0] ZERO  = LOG2NUMREGS'(ZERO_REG);
  localparam logic [LOG2NUMREGS:0]   DEPTH = (LOG2NUMREGS + 1)'(NUMREGS);
  state_e                 state_q;
  logic [LOG2NUMREGS-1:0] cnt_q;
  logic                   ready_q;
  logic                   init;
  logic                   bank_we;
  logic [LOG2NUMREGS-1:0] bank_addr;
  logic [WIDTH-1:0]       bank_wdata;
  assign init       = state_q == ST_INIT;
  // The sweep owns the shared write port until it finishes; user writes are dropped.
  assign bank_we    = init | (wr_we && wr_reg != ZERO);
  assign bank_addr  = init ? cnt_q : wr_reg;
  assign bank_wdata = init ? '0 : wr_data;
  assign ready      = ready_q;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else if (init) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_q <= ST_RUN;
        ready_q <= 1'b1;
      end
    end
  genvar i;
  generate
    for (i = 0; i < NUMRD; i++) begin : g_port
      logic [LOG2NUMREGS-1:0] raddr;
      logic [WIDTH-1:0]       bank_q, rd_data_d, rd_data_q;
      logic                   valid, hit;
      assign raddr = rd_reg[slice_off(i, LOG2NUMREGS) +: LOG2NUMREGS];
      reg_file_mp_bank #(
        .WIDTH(WIDTH), .NUMREGS(NUMREGS), .LOG2NUMREGS(LOG2NUMREGS)
      ) u_bank (
        .clk(clk), .we_i(bank_we), .waddr_i(bank_addr), .wdata_i(bank_wdata),
        .raddr_i(raddr), .rdata_o(bank_q)
      );
      assign valid = raddr != ZERO && {1'b0, raddr} < DEPTH;
`ifdef REG_FILE_MP_BYPASS_EN
      assign hit = wr_we && wr_reg == raddr;
`else
      assign hit = 1'b0;
`endif
      assign rd_data_d = !valid ? '0 : hit ? wr_data : bank_q;
      always_ff @(posedge clk or negedge resetn)
        if (!resetn) rd_data_q <= '0;
        else if (!init && rd_en[i]) rd_data_q <= rd_data_d;
      assign rd_data[slice_off(i, WIDTH) +: WIDTH] = rd_data_q;
    end
  endgenerate
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: reference-model bench for reg_file_mp (default instance and a 4-port, 24-entry instance).
module tb_reg_file_mp;
`ifdef REG_FILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;
  logic [9:0]   rd_reg_a = '0;
  logic [1:0]   rd_en_a = '0;
  logic [63:0]  rd_data_a;
  logic [4:0]   wr_reg_a = '0;
  logic [31:0]  wr_data_a = '0;
  logic         wr_we_a = 1'b0, ready_a;
  logic [19:0]  rd_reg_b = '0;
  logic [3:0]   rd_en_b = '0;
  logic [127:0] rd_data_b;
  logic [4:0]   wr_reg_b = '0;
  logic [31:0]  wr_data_b = '0;
  logic         wr_we_b = 1'b0, ready_b;
  int total = 0, passed = 0;

  reg_file_mp u_a (
    .clk(clk), .resetn(resetn), .rd_reg(rd_reg_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
    .wr_reg(wr_reg_a), .wr_data(wr_data_a), .wr_we(wr_we_a), .ready(ready_a)
  );
  reg_file_mp #(.WIDTH(32), .NUMREGS(24), .LOG2NUMREGS(5), .NUMRD(4)) u_b (
    .clk(clk), .resetn(resetn), .rd_reg(rd_reg_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
    .wr_reg(wr_reg_b), .wr_data(wr_data_b), .wr_we(wr_we_b), .ready(ready_b)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  // Model: storage array plus a count of edges since reset release; usable after NUMREGS edges.
  int ca, cb;
  bit ra, rb;
  logic [31:0] ma [32];
  logic [31:0] mb [24];
  logic [31:0] ea [2];
  logic [31:0] eb [4];
  always @(posedge clk) begin
    int a;
    if (!resetn) begin
      ca = 0; ra = 0;
      foreach (ma[k]) ma[k] = '0;
      foreach (ea[k]) ea[k] = '0;
    end else if (ra) begin
      for (int p = 0; p < 2; p++)
        if (rd_en_a[p]) begin
          a = int'(rd_reg_a[p*5 +: 5]);
          ea[p] = (a == 0) ? 32'd0 : (BYP && wr_we_a && int'(wr_reg_a) == a) ? wr_data_a : ma[a];
        end
      if (wr_we_a && wr_reg_a != 0) ma[wr_reg_a] = wr_data_a;
    end else begin
      ca++;
      if (ca == 32) ra = 1;
    end
    #1;
    chk("ready_a", ready_a, ra);
    chk("rd_data_a", rd_data_a, {ea[1], ea[0]});
  end
  always @(posedge clk) begin
    int a;
    if (!resetn) begin
      cb = 0; rb = 0;
      foreach (mb[k]) mb[k] = '0;
      foreach (eb[k]) eb[k] = '0;
    end else if (rb) begin
      for (int p = 0; p < 4; p++)
        if (rd_en_b[p]) begin
          a = int'(rd_reg_b[p*5 +: 5]);
          eb[p] = (a == 0 || a >= 24) ? 32'd0 :
                  (BYP && wr_we_b && int'(wr_reg_b) == a) ? wr_data_b : mb[a];
        end
      if (wr_we_b && wr_reg_b != 0 && wr_reg_b < 24) mb[wr_reg_b] = wr_data_b;
    end else begin
      cb++;
      if (cb == 24) rb = 1;
    end
    #1;
    chk("ready_b", ready_b, rb);
    chk("rd_data_b", rd_data_b, {eb[3], eb[2], eb[1], eb[0]});
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    n = 0;
    while (!ready_a && n < 100) begin @(negedge clk); n++; end
    chk("init_len", n, 32);
    chk("ready_b_up", ready_b, 1'b1);
    for (int r = 1; r < 32; r++) begin
      rd_en_a = 2'b11; rd_reg_a = {5'(r), 5'(r)};
      @(negedge clk);
    end
    chk("swept_zero", rd_data_a, 64'd0);
    rd_en_a = '0; wr_we_a = 1'b1; wr_reg_a = 5'd5; wr_data_a = 32'hDEADBEEF;
    @(negedge clk);
    wr_we_a = 1'b0; rd_en_a = 2'b11; rd_reg_a = {5'd5, 5'd5};
    @(negedge clk);
    chk("read5", rd_data_a, {32'hDEADBEEF, 32'hDEADBEEF});
    rd_en_a = '0; rd_reg_a = {5'd1, 5'd1};
    @(negedge clk);
    chk("hold5", rd_data_a, {32'hDEADBEEF, 32'hDEADBEEF});
    wr_we_a = 1'b1; wr_reg_a = 5'd0; wr_data_a = 32'h12345678;
    @(negedge clk);
    wr_we_a = 1'b0; rd_en_a = 2'b01; rd_reg_a = {5'd0, 5'd0};
    @(negedge clk);
    chk("reg0", rd_data_a, {32'hDEADBEEF, 32'd0});
    rd_en_a = '0; wr_we_a = 1'b1; wr_reg_a = 5'd7; wr_data_a = 32'h11;
    @(negedge clk);
    wr_data_a = 32'h22; rd_en_a = 2'b01; rd_reg_a = {5'd0, 5'd7};
    @(negedge clk);
    chk("collide", rd_data_a[31:0], BYP ? 32'h22 : 32'h11);
    wr_we_a = 1'b0;
    @(negedge clk);
    chk("after_collide", rd_data_a[31:0], 32'h22);
    rd_en_a = '0;
    resetn = 1'b0;
    @(negedge clk);
    chk("reset_out", {ready_a, rd_data_a}, 65'd0);
    resetn = 1'b1; wr_we_a = 1'b1; wr_reg_a = 5'd3; wr_data_a = 32'hAA;
    rd_en_a = 2'b11; rd_reg_a = {5'd5, 5'd5};
    n = 0;
    while (!ready_a && n < 100) begin @(negedge clk); n++; end
    chk("reinit_len", n, 32);
    chk("init_rd_zero", rd_data_a, 64'd0);
    wr_we_a = 1'b0; rd_reg_a = {5'd3, 5'd3};
    @(negedge clk);
    chk("init_wr_dropped", rd_data_a, 64'd0);
    rd_en_a = '0;
    wr_we_b = 1'b1; wr_reg_b = 5'd10; wr_data_b = 32'hCAFE;
    @(negedge clk);
    wr_reg_b = 5'd25; wr_data_b = 32'hFFFF;
    @(negedge clk);
    wr_we_b = 1'b0; rd_en_b = 4'hF; rd_reg_b = {5'd10, 5'd25, 5'd10, 5'd25};
    @(negedge clk);
    chk("b_pins", rd_data_b, {32'hCAFE, 32'd0, 32'hCAFE, 32'd0});
    for (int k = 0; k < 300; k++) begin
      wr_we_b = 1'($urandom); wr_reg_b = 5'($urandom); wr_data_b = $urandom;
      rd_en_b = 4'($urandom); rd_reg_b = 20'($urandom);
      @(negedge clk);
    end
    wr_we_b = 1'b0; rd_en_b = 4'hF; rd_reg_b = {4{5'd25}};
    @(negedge clk);
    chk("b_addr25", rd_data_b, 128'd0);
    rd_en_b = '0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
